// File: rtl/ex_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl_if
//   Bundles the pipeline-side hazard inputs and the control outputs of
//   ex_hazard_ctrl.
//   master : the pipeline. It drives the stage register/address info and
//            consumes the enables, forwarding selects and counters.
//   slave  : the hazard controller.
//   Parameters: ADDR_W (GPR address width), CNT_W (performance counter width).
// ----------------------------------------------------------------------------
interface ex_hazard_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 32
);
    // ID stage
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    // EX stage
    logic [ADDR_W-1:0] ex_rs;
    logic [ADDR_W-1:0] ex_rt;
    logic [ADDR_W-1:0] ex_reg_dest;
    logic              ex_reg_write_enable;
    logic [1:0]        ex_wb_res_mux;
    // MEM stage
    logic [ADDR_W-1:0] mem_reg_dest;
    logic              mem_reg_write_enable;
    logic [1:0]        mem_wb_res_mux;
    // WB stage
    logic [ADDR_W-1:0] wb_reg_dest;
    logic              wb_reg_write_enable;
    // control events
    logic              branch_taken;
    logic              mem_busy;
    // controller outputs
    logic [1:0]        fwd_rs_sel;
    logic [1:0]        fwd_rt_sel;
    logic              pc_write_enable;
    logic              if_id_write_enable;
    logic              id_ex_bubble;
    logic              pipe_flush;
    logic              pipe_freeze;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_rs, ex_rt, ex_reg_dest, ex_reg_write_enable, ex_wb_res_mux,
        output mem_reg_dest, mem_reg_write_enable, mem_wb_res_mux,
        output wb_reg_dest, wb_reg_write_enable,
        output branch_taken, mem_busy,
        input  fwd_rs_sel, fwd_rt_sel, pc_write_enable, if_id_write_enable,
        input  id_ex_bubble, pipe_flush, pipe_freeze, stall_count, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_rs, ex_rt, ex_reg_dest, ex_reg_write_enable, ex_wb_res_mux,
        input  mem_reg_dest, mem_reg_write_enable, mem_wb_res_mux,
        input  wb_reg_dest, wb_reg_write_enable,
        input  branch_taken, mem_busy,
        output fwd_rs_sel, fwd_rt_sel, pc_write_enable, if_id_write_enable,
        output id_ex_bubble, pipe_flush, pipe_freeze, stall_count, flush_count
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl
//   EX-stage sequencer: operand forwarding selects, load-use stall, flush on a
//   taken branch resolved in MEM, and whole-pipe freeze while data memory is
//   busy. After reset the pipe is held empty for STARTUP_CYCLES cycles.
//   Saturating counters track load-use stall cycles and redirects.
// Ports
//   clk  : clock, all state on posedge
//   rst  : asynchronous reset, active-high
//   hz   : ex_hazard_ctrl_if.slave (stage info in, enables/selects/counters out)
// ----------------------------------------------------------------------------
module ex_hazard_ctrl #(
    parameter int         ADDR_W         = 4,
    parameter int         CNT_W          = 32,
    parameter logic [1:0] WB_SEL_MEM     = 2'b01,
    parameter int         STARTUP_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    ex_hazard_ctrl_if.slave  hz
);

    localparam int INIT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(STARTUP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [INIT_W-1:0] init_cnt_q,  init_cnt_d;
    logic              pending_q,   pending_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [1:0] fwd_rs, fwd_rt;
    logic       pc_we, if_id_we, bubble, flush, freeze;
    logic       load_use;

    // MEM wins over WB because it holds the younger value. A load in MEM has
    // no result on the EX/MEM alu_res path, so only WB may supply it.
    function automatic logic [1:0] fwd_sel(
        input logic [ADDR_W-1:0] src,
        input logic              mem_we,
        input logic [ADDR_W-1:0] mem_dest,
        input logic [1:0]        mem_mux,
        input logic              wb_we,
        input logic [ADDR_W-1:0] wb_dest
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (mem_we && mem_dest == src && mem_mux != WB_SEL_MEM)
                sel = 2'b01;
            else if (wb_we && wb_dest == src)
                sel = 2'b10;
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        load_use = hz.ex_reg_write_enable && hz.ex_wb_res_mux == WB_SEL_MEM &&
                   hz.ex_reg_dest != '0 &&
                   ((hz.id_use_rs && hz.id_rs == hz.ex_reg_dest) ||
                    (hz.id_use_rt && hz.id_rt == hz.ex_reg_dest));
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        pending_d   = pending_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        fwd_rs      = 2'b00;
        fwd_rt      = 2'b00;
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        bubble      = 1'b0;
        flush       = 1'b0;
        freeze      = 1'b0;

        if (state_q == ST_INIT) begin
            // Hold the pipe empty: nothing fetched, bubbles and flushes everywhere.
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            bubble   = 1'b1;
            flush    = 1'b1;
            if (init_cnt_q == '0) state_d = ST_RUN;
            else                  init_cnt_d = init_cnt_q - 1'b1;
        end else begin
            fwd_rs = fwd_sel(hz.ex_rs, hz.mem_reg_write_enable, hz.mem_reg_dest,
                             hz.mem_wb_res_mux, hz.wb_reg_write_enable, hz.wb_reg_dest);
            fwd_rt = fwd_sel(hz.ex_rt, hz.mem_reg_write_enable, hz.mem_reg_dest,
                             hz.mem_wb_res_mux, hz.wb_reg_write_enable, hz.wb_reg_dest);
            if (hz.mem_busy) begin
                // Freeze asserts combinationally in the cycle busy rises; a
                // redirect seen now is remembered until memory is free.
                state_d  = ST_FREEZE;
                freeze   = 1'b1;
                pc_we    = 1'b0;
                if_id_we = 1'b0;
                if (hz.branch_taken) pending_d = 1'b1;
            end else begin
                // The exit cycle of FREEZE behaves like RUN so a held
                // redirect or a load-use pair sitting in ID/EX is handled.
                state_d = ST_RUN;
                if (hz.branch_taken || pending_q) begin
                    flush       = 1'b1;
                    pending_d   = 1'b0;
                    flush_cnt_d = sat_inc(flush_cnt_q);
                end else if (load_use) begin
                    pc_we       = 1'b0;
                    if_id_we    = 1'b0;
                    bubble      = 1'b1;
                    stall_cnt_d = sat_inc(stall_cnt_q);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= INIT_LOAD;
            pending_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.fwd_rs_sel         = fwd_rs;
    assign hz.fwd_rt_sel         = fwd_rt;
    assign hz.pc_write_enable    = pc_we;
    assign hz.if_id_write_enable = if_id_we;
    assign hz.id_ex_bubble       = bubble;
    assign hz.pipe_flush         = flush;
    assign hz.pipe_freeze        = freeze;
    assign hz.stall_count        = stall_cnt_q;
    assign hz.flush_count        = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_hazard_ctrl
//   Directed scenarios plus randomized traffic against a cycle-level reference
//   model built from the hazard rules. Counters are narrowed so saturation is
//   reachable.
// ----------------------------------------------------------------------------
module tb_ex_hazard_ctrl;
    localparam int ADDR_W  = 4;
    localparam int CNT_W   = 5;
    localparam int STARTUP = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_hazard_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) hz();

    ex_hazard_ctrl #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .WB_SEL_MEM(2'b01), .STARTUP_CYCLES(STARTUP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int cyc_since_rst;
    bit m_pend;
    int m_stall, m_flush;

    // last observed values, for directed checks
    logic obs_pc, obs_frz, obs_fl, obs_bub;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [ADDR_W-1:0] src);
        if (src == 0) return 2'b00;
        if (hz.mem_reg_write_enable && hz.mem_reg_dest == src && hz.mem_wb_res_mux != 2'b01)
            return 2'b01;
        if (hz.wb_reg_write_enable && hz.wb_reg_dest == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        hz.id_rs = 0; hz.id_rt = 0; hz.id_use_rs = 0; hz.id_use_rt = 0;
        hz.ex_rs = 0; hz.ex_rt = 0; hz.ex_reg_dest = 0; hz.ex_reg_write_enable = 0;
        hz.ex_wb_res_mux = 0; hz.mem_reg_dest = 0; hz.mem_reg_write_enable = 0;
        hz.mem_wb_res_mux = 0; hz.wb_reg_dest = 0; hz.wb_reg_write_enable = 0;
        hz.branch_taken = 0; hz.mem_busy = 0;
    endtask

    task automatic rand_inputs();
        hz.id_rs = ADDR_W'($urandom_range(0, 3)); hz.id_rt = ADDR_W'($urandom_range(0, 3));
        hz.id_use_rs = 1'($urandom); hz.id_use_rt = 1'($urandom);
        hz.ex_rs = ADDR_W'($urandom_range(0, 3)); hz.ex_rt = ADDR_W'($urandom_range(0, 3));
        hz.ex_reg_dest = ADDR_W'($urandom_range(0, 3));
        hz.ex_reg_write_enable = 1'($urandom);
        hz.ex_wb_res_mux = 2'($urandom_range(0, 3));
        hz.mem_reg_dest = ADDR_W'($urandom_range(0, 3));
        hz.mem_reg_write_enable = 1'($urandom);
        hz.mem_wb_res_mux = 2'($urandom_range(0, 3));
        hz.wb_reg_dest = ADDR_W'($urandom_range(0, 3));
        hz.wb_reg_write_enable = 1'($urandom);
        hz.branch_taken = ($urandom_range(0, 9) == 0);
        hz.mem_busy = ($urandom_range(0, 4) == 0);
    endtask

    // One clock: compare everything against the model at negedge, advance
    // the model, then move inputs 1 time unit after the posedge.
    task automatic step();
        logic e_pc, e_ifid, e_bub, e_fl, e_frz;
        logic [1:0] e_rs, e_rt;
        bit lu;
        @(negedge clk);
        e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 0; e_frz = 0; e_rs = 0; e_rt = 0;
        chk("stall_count", hz.stall_count, m_stall);
        chk("flush_count", hz.flush_count, m_flush);
        if (cyc_since_rst < STARTUP) begin
            e_pc = 0; e_ifid = 0; e_bub = 1; e_fl = 1;
        end else begin
            e_rs = m_fwd(hz.ex_rs);
            e_rt = m_fwd(hz.ex_rt);
            lu = hz.ex_reg_write_enable && hz.ex_wb_res_mux == 2'b01 && hz.ex_reg_dest != 0 &&
                 ((hz.id_use_rs && hz.id_rs == hz.ex_reg_dest) ||
                  (hz.id_use_rt && hz.id_rt == hz.ex_reg_dest));
            if (hz.mem_busy) begin
                e_frz = 1; e_pc = 0; e_ifid = 0;
                if (hz.branch_taken) m_pend = 1;
            end else if (hz.branch_taken || m_pend) begin
                e_fl = 1; m_pend = 0;
                if (m_flush < CNT_MAX) m_flush++;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; e_bub = 1;
                if (m_stall < CNT_MAX) m_stall++;
            end
        end
        chk("fwd_rs_sel", hz.fwd_rs_sel, e_rs);
        chk("fwd_rt_sel", hz.fwd_rt_sel, e_rt);
        chk("pc_we", hz.pc_write_enable, e_pc);
        chk("if_id_we", hz.if_id_write_enable, e_ifid);
        chk("bubble", hz.id_ex_bubble, e_bub);
        chk("flush", hz.pipe_flush, e_fl);
        chk("freeze", hz.pipe_freeze, e_frz);
        obs_pc = hz.pc_write_enable; obs_frz = hz.pipe_freeze;
        obs_fl = hz.pipe_flush;      obs_bub = hz.id_ex_bubble;
        if (cyc_since_rst < 1000) cyc_since_rst++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pc_we", hz.pc_write_enable, 1'b0);
        chk("rst_flush", hz.pipe_flush, 1'b1);
        chk("rst_stall_cnt", hz.stall_count, 0);
        chk("rst_flush_cnt", hz.flush_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc_since_rst = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic set_load_use();
        hz.ex_reg_dest = 5; hz.ex_reg_write_enable = 1; hz.ex_wb_res_mux = 2'b01;
        hz.id_rt = 5; hz.id_use_rt = 1;
    endtask

    initial begin
        int held;
        int nfrz;
        idle_inputs();
        #1;
        apply_reset();

        // startup hold length
        held = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (!obs_pc) held++;
        end
        chk("init_hold_len", held, STARTUP);
        chk("run_pc_we", obs_pc, 1'b1);

        // forwarding priority
        hz.ex_rs = 3; hz.mem_reg_dest = 3; hz.mem_reg_write_enable = 1; hz.mem_wb_res_mux = 2'b00;
        hz.wb_reg_dest = 3; hz.wb_reg_write_enable = 1;
        #1 chk("fwd_mem_alu", hz.fwd_rs_sel, 2'b01);
        step();
        hz.mem_wb_res_mux = 2'b01;
        #1 chk("fwd_mem_load_wb", hz.fwd_rs_sel, 2'b10);
        step();
        hz.wb_reg_write_enable = 0;
        #1 chk("fwd_mem_load_none", hz.fwd_rs_sel, 2'b00);
        step();
        hz.ex_rs = 0; hz.mem_reg_dest = 0; hz.mem_wb_res_mux = 2'b00;
        #1 chk("fwd_r0", hz.fwd_rs_sel, 2'b00);
        step();
        idle_inputs();

        // single load-use stall
        set_load_use();
        step();
        chk("lu_bubble", obs_bub, 1'b1);
        chk("lu_pc_we", obs_pc, 1'b0);
        idle_inputs();
        step();
        chk("lu_stall_cnt", hz.stall_count, 1);

        // load-use together with a redirect: flush wins
        apply_reset();
        for (int i = 0; i < STARTUP; i++) step();
        set_load_use();
        hz.branch_taken = 1;
        step();
        chk("lu_br_flush", obs_fl, 1'b1);
        chk("lu_br_pc_we", obs_pc, 1'b1);
        idle_inputs();
        step();
        chk("lu_br_flush_cnt", hz.flush_count, 1);
        chk("lu_br_stall_cnt", hz.stall_count, 0);

        // redirect held across a 3-cycle memory stall
        apply_reset();
        for (int i = 0; i < STARTUP; i++) step();
        nfrz = 0;
        hz.branch_taken = 1; hz.mem_busy = 1;
        step(); nfrz += int'(obs_frz);
        hz.branch_taken = 0;
        step(); nfrz += int'(obs_frz);
        step(); nfrz += int'(obs_frz);
        chk("busy_no_flush", obs_fl, 1'b0);
        hz.mem_busy = 0;
        step();
        chk("busy_frz_len", nfrz, 3);
        chk("busy_flush_4th", obs_fl, 1'b1);
        step();
        chk("busy_flush_cnt", hz.flush_count, 1);

        // stall counter saturation
        set_load_use();
        for (int i = 0; i < CNT_MAX + 6; i++) step();
        chk("stall_sat", hz.stall_count, CNT_MAX);
        idle_inputs();

        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            rand_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
